// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain driver: op encodings, FSM states and
// the bytes-per-operation helper.
package scan_pkg;

  localparam logic [1:0] OP_ILLEGAL  = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] OP_EXCHANGE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET   = 3'd1,
    S_SHIFT = 3'd2,
    S_PUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic int nbytes(input int len);
    return (len + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_chain_driver_if.sv
// Host-side command, write-byte and read-byte channels of the scan chain driver.
// Every channel transfers on a clock edge where valid and ready are both high;
// the sender holds valid and its payload stable until that edge.
interface scan_chain_driver_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/scan_byte_serdes.sv
// One-byte serialiser/deserialiser: shifts a loaded byte out LSB first while
// capturing the returning scan bits into bit0 upward.
module scan_byte_serdes (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_shift,
  input  logic       i_scan_out,
  output logic       o_bit,
  output logic [7:0] o_cap,
  output logic [3:0] o_bit_cnt
);

  logic [7:0] r_sout;
  logic [7:0] r_cap;
  logic [3:0] r_cnt;

  // A load also clears the capture byte so a short last byte reads back 0 above bit n-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sout <= 8'h00;
      r_cap  <= 8'h00;
      r_cnt  <= 4'd0;
    end else if (i_load) begin
      r_sout <= i_load_data;
      r_cap  <= 8'h00;
      r_cnt  <= 4'd0;
    end else if (i_shift) begin
      r_sout              <= {1'b0, r_sout[7:1]};
      r_cap[r_cnt[2:0]]   <= i_scan_out;
      r_cnt               <= r_cnt + 4'd1;
    end
  end

  assign o_bit     = r_sout[0];
  assign o_cap     = r_cap;
  assign o_bit_cnt = r_cnt;

endmodule

// File: rtl/scan_chain_driver.sv
// Host-side scan chain initiator: turns byte-stream WRITE/READ/EXCHANGE
// commands into bit-serial shifts of a CHAIN_LEN chain, holding the processor.
module scan_chain_driver
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 48
) (
  input  logic                clk,
  input  logic                rst,
  scan_chain_driver_if.slave  bus,
  output logic                scan_enable,
  output logic                scan_in,
  input  logic                scan_out,
  output logic                proc_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output state_t              o_dbg_state
);

  localparam int NBYTES = nbytes(CHAIN_LEN);
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t        r_state;
  logic [1:0]    r_op;
  logic [BW-1:0] r_byte;
  logic          r_cmd_ready;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_scan_enable;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_load;
  logic [7:0]    w_load_data;
  logic          w_shift;
  logic          w_bit;
  logic [7:0]    w_cap;
  logic [3:0]    w_bit_cnt;
  logic [3:0]    w_last_bit;
  logic          w_last_byte;
  logic          w_writes;
  logic          w_captures;
  int            w_rem;

  assign w_writes    = r_op[0];
  assign w_captures  = r_op[1];
  assign w_last_byte = (r_byte == BW'(NBYTES - 1));
  assign w_shift     = (r_state == S_SHIFT);

  // The final byte may carry fewer than 8 chain bits.
  always_comb begin
    w_rem      = CHAIN_LEN - 8 * int'(r_byte);
    w_last_bit = (w_rem >= 8) ? 4'd7 : 4'(w_rem - 1);
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_data = 8'h00;
    case (r_state)
      S_IDLE:  w_load = bus.cmd_valid && (bus.cmd_op == OP_READ);
      S_GET: begin
        w_load      = bus.in_valid;
        w_load_data = bus.in_data;
      end
      S_PUT:   w_load = bus.out_ready && !w_last_byte && !w_writes;
      default: w_load = 1'b0;
    endcase
  end

  scan_byte_serdes u_serdes (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (w_load_data),
    .i_shift     (w_shift),
    .i_scan_out  (scan_out),
    .o_bit       (w_bit),
    .o_cap       (w_cap),
    .o_bit_cnt   (w_bit_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_ILLEGAL;
      r_byte        <= '0;
      r_cmd_ready   <= 1'b1;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_scan_enable <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_op == OP_ILLEGAL) begin
              r_err <= 1'b1;
            end else begin
              r_op        <= bus.cmd_op;
              r_byte      <= '0;
              r_busy      <= 1'b1;
              r_cmd_ready <= 1'b0;
              if (bus.cmd_op == OP_READ) begin
                r_state       <= S_SHIFT;
                r_scan_enable <= 1'b1;
              end else begin
                r_state    <= S_GET;
                r_in_ready <= 1'b1;
              end
            end
          end
        end
        S_GET: begin
          if (bus.in_valid) begin
            r_state       <= S_SHIFT;
            r_in_ready    <= 1'b0;
            r_scan_enable <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_bit_cnt == w_last_bit) begin
            r_scan_enable <= 1'b0;
            if (w_captures) begin
              r_state     <= S_PUT;
              r_out_valid <= 1'b1;
            end else if (w_last_byte) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_GET;
              r_in_ready <= 1'b1;
              r_byte     <= r_byte + BW'(1);
            end
          end
        end
        S_PUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (w_last_byte) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_byte <= r_byte + BW'(1);
              if (w_writes) begin
                r_state    <= S_GET;
                r_in_ready <= 1'b1;
              end else begin
                r_state       <= S_SHIFT;
                r_scan_enable <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // READ recirculates scan_out so the chain is left intact.
  assign scan_in       = r_scan_enable & (w_writes ? w_bit : scan_out);
  assign scan_enable   = r_scan_enable;
  assign proc_hold     = r_busy;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign o_dbg_state   = r_state;

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_cap;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: a 12-bit and a 3-bit chain instance, each with a
// behavioural chain, checked against a bit-list model of the chain contents.
module tb_scan_chain_driver;
  import scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- host drive (shared, routed by sel) ----------------
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  scan_chain_driver_if if12();
  scan_chain_driver_if if3();

  assign if12.cmd_valid = cmd_valid & ~sel;
  assign if12.cmd_op    = cmd_op;
  assign if12.in_valid  = in_valid & ~sel;
  assign if12.in_data   = in_data;
  assign if12.out_ready = out_ready & ~sel;
  assign if3.cmd_valid  = cmd_valid & sel;
  assign if3.cmd_op     = cmd_op;
  assign if3.in_valid   = in_valid & sel;
  assign if3.in_data    = in_data;
  assign if3.out_ready  = out_ready & sel;

  logic   se12, si12, ph12, busy12, done12, err12;
  logic   se3, si3, ph3, busy3, done3, err3;
  state_t dbg12, dbg3;
  logic [11:0] chain12;
  logic [2:0]  chain3;

  scan_chain_driver #(.CHAIN_LEN(12)) u_dut12 (
    .clk(clk), .rst(rst), .bus(if12.slave),
    .scan_enable(se12), .scan_in(si12), .scan_out(chain12[11]),
    .proc_hold(ph12), .busy(busy12), .done(done12), .err(err12),
    .o_dbg_state(dbg12)
  );

  scan_chain_driver #(.CHAIN_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
    .scan_enable(se3), .scan_in(si3), .scan_out(chain3[2]),
    .proc_hold(ph3), .busy(busy3), .done(done3), .err(err3),
    .o_dbg_state(dbg3)
  );

  // Observed signals of the currently selected instance
  logic       m_cmd_ready, m_in_ready, m_out_valid, m_se, m_si, m_ph, m_busy, m_done, m_err;
  logic [7:0] m_out_data;
  state_t     m_dbg;
  assign m_cmd_ready = sel ? if3.cmd_ready : if12.cmd_ready;
  assign m_in_ready  = sel ? if3.in_ready  : if12.in_ready;
  assign m_out_valid = sel ? if3.out_valid : if12.out_valid;
  assign m_out_data  = sel ? if3.out_data  : if12.out_data;
  assign m_se        = sel ? se3   : se12;
  assign m_si        = sel ? si3   : si12;
  assign m_ph        = sel ? ph3   : ph12;
  assign m_busy      = sel ? busy3 : busy12;
  assign m_done      = sel ? done3 : done12;
  assign m_err       = sel ? err3  : err12;
  assign m_dbg       = sel ? dbg3  : dbg12;

  // Behavioural scan chains plus event counters
  int shifts = 0, done_cnt = 0, err_cnt = 0, op_cycles = 0;
  always @(posedge clk) begin
    if (se12) chain12 <= {chain12[10:0], si12};
    if (se3)  chain3  <= {chain3[1:0], si3};
    if (m_se) shifts <= shifts + 1;
    if (m_done) done_cnt <= done_cnt + 1;
    if (m_err) err_cnt <= err_cnt + 1;
    if (m_busy | m_done) op_cycles <= op_cycles + 1;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [63:0] ref_chain [2];    // bit j = chain[j]
  logic [7:0]  wr [2];
  logic [7:0]  exp_q [$];
  int n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic int cur_len();
    return sel ? 3 : 12;
  endfunction

  function automatic logic [63:0] chain_now();
    return sel ? {61'd0, chain3} : {52'd0, chain12};
  endfunction

  function automatic logic sig_of(input int w);
    case (w)
      0: return m_in_ready;
      1: return m_out_valid;
      default: return m_done;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w);
    int n = 0;
    while (!sig_of(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sig_of(w)) chk(tag, 0, 1);
  endtask

  // Runs one full operation from the host side; stalls are exact or random up to the given max.
  task automatic run_op(input logic [1:0] op, input int st_in, input int st_out, input bit rnd);
    int len, nb, s0, d0, c0, stall, total_stall, exp_cyc;
    logic [63:0] old;
    logic [7:0]  first, e;
    bit writes, caps;
    len = cur_len();
    nb = (len + 7) / 8;
    writes = op[0];
    caps = op[1];
    old = ref_chain[sel];
    total_stall = 0;
    if (caps) begin
      for (int b = 0; b < nb; b++) begin
        e = 8'h00;
        for (int i = 0; i < 8; i++)
          if (8 * b + i < len) e[i] = old[len - 1 - (8 * b + i)];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    s0 = shifts; d0 = done_cnt; c0 = op_cycles;
    chk("cmd_ready_idle", m_cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_after_accept", {m_busy, m_ph, m_cmd_ready}, 3'b110);
    for (int b = 0; b < nb; b++) begin
      if (writes) begin
        wait_for("to_in_ready", 0);
        stall = rnd ? $urandom_range(0, st_in) : st_in;
        total_stall += stall;
        repeat (stall) begin
          chk("in_stall_se_rdy", {m_se, m_in_ready}, 2'b01);
          @(negedge clk);
        end
        in_data = wr[b];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 8'($urandom);
      end
      if (caps) begin
        wait_for("to_out_valid", 1);
        first = m_out_data;
        stall = rnd ? $urandom_range(0, st_out) : st_out;
        total_stall += stall;
        repeat (stall) begin
          @(negedge clk);
          chk("out_stall_hold", {m_se, m_out_valid, m_out_data}, {2'b01, first});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        e = exp_q.pop_front();
        chk("rd_byte", first, e);
      end
    end
    wait_for("to_done", 2);
    chk("done_busy_drop", {m_done, m_busy, m_ph}, 3'b100);
    @(negedge clk);
    chk("idle_after_done", {m_done, m_cmd_ready, m_busy}, 3'b010);
    chk("done_once", done_cnt - d0, 1);
    chk("shift_count", shifts - s0, len);
    if (total_stall == 0) begin
      exp_cyc = (writes && caps) ? len + 2 * nb + 1 : len + nb + 1;
      chk("op_cycles", op_cycles - c0, exp_cyc);
    end
    if (writes) begin
      for (int k = 0; k < len; k++) ref_chain[sel][len - 1 - k] = wr[k / 8][k % 8];
    end
    chk("chain_contents", chain_now(), ref_chain[sel]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0, d0, e0, n;
    ref_chain[0] = '0;
    ref_chain[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {m_cmd_ready, m_in_ready, m_out_valid, m_se, m_si, m_ph, m_busy, m_done, m_err},
        9'b100000000);
    chk("reset_data", m_out_data, 8'h00);
    chk("reset_state", m_dbg, S_IDLE);
    rst = 1'b1;

    // Write, then two non-destructive reads
    wr[0] = 8'hA5; wr[1] = 8'h03;
    run_op(OP_WRITE, 0, 0, 0);
    chk("chain_after_write", chain12, 12'b1010_0101_1100);
    run_op(OP_READ, 0, 0, 0);
    run_op(OP_READ, 0, 0, 0);

    // Exchange returns the old contents; upper nibble of the short byte is dropped
    wr[0] = 8'hFF; wr[1] = 8'hFF;
    run_op(OP_EXCHANGE, 0, 0, 0);
    run_op(OP_READ, 0, 0, 0);
    chk("chain_all_ones", chain12, 12'hFFF);

    // Exchange under backpressure on both host channels
    wr[0] = 8'h3C; wr[1] = 8'h09;
    run_op(OP_EXCHANGE, 3, 5, 0);

    // Illegal op
    @(negedge clk);
    e0 = err_cnt;
    cmd_valid = 1'b1; cmd_op = OP_ILLEGAL;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("illegal_first", {m_err, m_busy, m_ph, m_se, m_cmd_ready}, 5'b10001);
    @(negedge clk);
    chk("illegal_next", {m_err, m_busy, m_ph, m_se, m_cmd_ready}, 5'b00001);
    chk("err_once", err_cnt - e0, 1);

    // Reset during shift cycle 5 of a WRITE
    s0 = shifts; d0 = done_cnt;
    cmd_valid = 1'b1; cmd_op = OP_WRITE;
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (shifts - s0 < 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_shift_active", m_se, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", {m_se, m_busy, m_ph, m_cmd_ready}, 4'b0001);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    wr[0] = 8'h5A; wr[1] = 8'h0C;
    run_op(OP_WRITE, 0, 0, 0);
    run_op(OP_READ, 0, 0, 0);

    // Three-bit chain
    sel = 1'b1;
    wr[0] = 8'h02; wr[1] = 8'h00;
    run_op(OP_WRITE, 0, 0, 0);
    chk("chain3_value", chain3, 3'b010);
    run_op(OP_READ, 0, 0, 0);

    // Randomised mix on both chains
    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      sel = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(1, 3));
      wr[0] = 8'($urandom);
      wr[1] = 8'($urandom);
      run_op(op, 4, 4, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_driver.md
Name: scan_chain_driver

Overview:
Host-side initiator for the processor scan chain: it drives scan_enable and scan_in, and captures scan_out.
It converts byte-stream host transfers into bit-serial WRITE, READ (non-destructive) and EXCHANGE operations over a chain of CHAIN_LEN flops.
It holds the processor via proc_hold while shifting.
It sits between the debug/config host interface and the scan ports of the control unit and datapath registers.

Parameters:
CHAIN_LEN, 48, total scan chain length in bits (>=1)
NBYTES, ceil(CHAIN_LEN/8), derived localparam: bytes per operation

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  01 WRITE, 10 READ, 11 EXCHANGE, 00 illegal
in_valid  in  1  host write byte valid
in_ready  out  1  byte accepted when in_valid&in_ready
in_data  in  8  host write byte, LSB shifted first
out_valid  out  1  captured byte valid
out_ready  in  1  host accepts captured byte
out_data  out  8  captured byte, bit0 = first bit captured
scan_enable  out  1  chain shifts one bit on every clk where high
scan_in  out  1  serial data into chain
scan_out  in  1  serial data from chain (registered in chain)
proc_hold  out  1  processor must not advance while high
busy  out  1  operation in progress
done  out  1  one-cycle pulse after the last bit/byte of an operation
err  out  1  one-cycle pulse on an illegal op

Behaviour:
- Chain model: scan_out = chain[LEN-1]; each shift, chain <= {chain[LEN-2:0], scan_in}.
- Host bit k means byte k/8, bit k%8. It is driven on shift cycle k.
- After a full WRITE, chain[LEN-1-k] = host bit k.
- Capture: out bit k = scan_out sampled on shift cycle k. WRITE and READ orderings are therefore symmetric.
- Reset (rst=0 at clk edge) sets all outputs to 0 except cmd_ready=1. State returns to IDLE.
- States: IDLE, GET (WRITE/EXCHANGE only), SHIFT, PUT (READ/EXCHANGE only), DONE.
- IDLE:
  - On cmd_valid with a legal op: latch the op, clear the byte and bit counters, set busy=proc_hold=1.
  - Next state is GET for WRITE/EXCHANGE, SHIFT for READ.
  - On op 00: pulse err next cycle, stay in IDLE, no shift.
- GET: in_ready=1. On handshake, load in_data into the shift-out register and go to SHIFT.
- SHIFT: scan_enable=1 for n = min(8, CHAIN_LEN-8*byte) consecutive cycles.
  - scan_in = shift-out reg bit0 for WRITE/EXCHANGE.
  - scan_in = scan_out (recirculate, chain preserved) for READ.
  - scan_out is shifted into the capture register; captured bits land at bit0..n-1 and bits n..7 are 0.
- After SHIFT:
  - Go to PUT if the op captures.
  - Otherwise, if bytes remain, go to GET; else go to DONE.
- PUT: out_valid=1 with stable out_data until out_ready. After the handshake, go to the next byte (GET or SHIFT) or to DONE.
- DONE: done=1 for one cycle; busy and proc_hold drop the same cycle; next state IDLE.
- Backpressure:
  - scan_enable is never high in GET or PUT, so in_valid/out_ready stalls lose no bits and cause no extra shifts.
- Last partial byte: in_data bits n..7 are ignored.
- Minimum cycles:
  - WRITE: NBYTES + CHAIN_LEN + 1.
  - READ: CHAIN_LEN + NBYTES + 1.
  - EXCHANGE: CHAIN_LEN + 2*NBYTES + 1.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset mid-operation:
  - Aborts immediately and scan_enable=0 from that edge.
  - No done pulse.
  - Chain contents are undefined; the host must re-WRITE.
- proc_hold rises on the edge after command acceptance, before the first scan_enable cycle.

Decomposition:
- Shared package scan_pkg:
  - op encodings OP_WRITE/OP_READ/OP_EXCHANGE/OP_ILLEGAL;
  - state enum;
  - function nbytes(len) = ceil(len/8).
- One natural sub-module: scan_byte_serdes.
  - Contents: the 8-bit shift-out register plus the 8-bit capture register, with a 4-bit bit counter.
  - Controls: load and shift.
  - Outputs: the serial bit and the captured byte.
- The top level holds the FSM, byte counter and handshakes.

Test Plan:
- CHAIN_LEN=12, WRITE 0xA5,0x03, then READ -> out bytes 0xA5,0x03; exactly 12 scan_enable cycles per op; chain unchanged after READ (second READ gives 0xA5,0x03).
- After the above, EXCHANGE 0xFF,0xFF -> returns 0xA5,0x03; following READ returns 0xFF,0x0F (upper nibble ignored and read back 0).
- EXCHANGE with out_ready held low 5 cycles at byte 0 and in_valid low 3 cycles before byte 1 -> out_valid/out_data stable, scan_enable 0 throughout the stalls, total shifts still 12, data correct.
- cmd_op=00 -> err pulse 1 cycle, busy/proc_hold/scan_enable stay 0, cmd_ready stays 1.
- rst=0 on shift cycle 5 of a WRITE -> next cycle scan_enable=0, busy=0, no done; subsequent WRITE 0x5A,0x0C then READ returns 0x5A,0x0C.
- CHAIN_LEN=3 (state-register-only chain): WRITE 0x02 -> chain = 3'b010; READ returns 0x02; done pulses once per op.
